fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Controls the SPU instruction-fetch front end. Sequences the program counter one instruction pair per fetch:
//   - gates PC advance via pc_stall;
//   - applies branch/stop redirects via pc_redirect/pc_target;
//   - runs the req/ready handshake to instruction memory;
//   - squashes fetches made stale by a redirect and halts on stop or memory timeout.
//  Sits between the hazard/branch logic, the PC register, instruction memory and the decode queue.
// PARAMETERS
//  ADDR_W   10  PC/instruction-address width, bits [0:ADDR_W-1], bit 0 = MSB
//  TIMEOUT  15  max cycles in WAIT without imem_ready before fetch_err (1..255)
// PORTS
//  clk          in   1       single clock, all logic on posedge
//  rst          in   1       synchronous, active-low reset (sampled on posedge clk, low = reset)
//  pc_cur       in   ADDR_W  current PC value
//  pc_stall     out  1       1 = PC holds; 0 = PC loads (+2 or pc_target)
//  pc_redirect  out  1       1 = PC loads pc_target instead of +2 (only with pc_stall=0)
//  pc_target    out  ADDR_W  redirect target, bit ADDR_W-1 always 0
//  imem_req     out  1       single-cycle fetch request
//  imem_addr    out  ADDR_W  fetch address, valid with imem_req, held through WAIT
//  imem_ready   in   1       fetched pair valid this cycle
//  fetch_valid  out  1       pair forwarded to decode queue this cycle
//  ifq_full     in   1       decode queue cannot accept another pair
//  hazard_stall in   1       hazard unit blocks new fetches
//  br_valid     in   1       branch resolved taken this cycle
//  br_target    in   ADDR_W  branch target
//  stop_req     in   1       stop instruction retired
//  flush        out  1       1-cycle pulse: decode queue discards contents
//  halted       out  1       sticky, cleared only by reset
//  fetch_err    out  1       sticky timeout flag, cleared only by reset
// BEHAVIOUR
//  Reset values (rst=0 at posedge):
//   - state=IDLE, pc_stall=1, imem_req=0, fetch_valid=0, flush=0;
//   - pc_redirect=0, pc_target=0, halted=0, fetch_err=0;
//   - pend_v=0, wait_cnt=0.
//  Reset mid-WAIT abandons the request; a late imem_ready is ignored (IDLE state).
//  States:
//   - IDLE: entered from reset; next cycle go to FETCH.
//   - FETCH: imem_req=1 and imem_addr=pc_cur for 1 cycle, latch addr; go to WAIT.
//   - WAIT: wait_cnt++ each cycle; on imem_ready go to ack cycle.
//   - HOLD: idle between fetches.
//   - HALT: pc_stall=1, no requests.
//  IDLE/HOLD -> FETCH when !ifq_full && !hazard_stall; otherwise stay.
//  Ack (WAIT with imem_ready):
//   - if !squash: fetch_valid=1, pc_stall=0, PC +2;
//   - if squash: fetch_valid=0, pc_redirect=1, pc_target=pend_tgt, pc_stall=0, clear pend_v/squash;
//   - wait_cnt cleared;
//   - next = FETCH if !ifq_full && !hazard_stall, else HOLD.
//  pc_stall=1 in every cycle not listed as an update cycle. PC never moves during WAIT.
//  Branch in IDLE/FETCH/HOLD:
//   - same cycle: pc_redirect=1, pc_stall=0, pc_target={br_target[0:ADDR_W-2],1'b0}, flush=1;
//   - FETCH issued this cycle is squashed (go WAIT with squash=1, pend = same target, redirect not repeated);
//   - otherwise go to FETCH.
//  Branch in WAIT:
//   - capture pend_tgt, set pend_v/squash, flush=1;
//   - a later branch before ready overwrites pend_tgt (youngest wins), flush pulses again.
//  Branch in same cycle as imem_ready: treated as squash of that pair; redirect applied in that ack cycle.
//  stop_req (priority over br_valid, which is dropped):
//   - outside WAIT: go to HALT next cycle, flush=1;
//   - in WAIT: squash set, HALT after ready/timeout.
//   - halted=1 from HALT entry.
//  Timeout: wait_cnt==TIMEOUT-1 without imem_ready -> fetch_err=1, halted=1, HALT.
//  Address wrap: pc +2 from {ADDR_W{1}}-1 wraps to 0 (PC-owned, not checked here).
//  hazard_stall/ifq_full never abort an outstanding request, only block the next FETCH.
// STRUCTURE
//  Shared package spu_fetch_pkg.vh:
//   - state localparams (IDLE/FETCH/WAIT/HOLD/HALT, 3-bit);
//   - INSTR_PAIR_STEP=2;
//   - default ADDR_W.
//  One sub-module: fetch_timeout_ctr (clear/enable/expire, width $clog2(TIMEOUT+1)).
//  Everything else (FSM, pend_tgt/pend_v/squash regs, output decode) in fetch_sequencer.
// TESTING
//  1. rst=0 2 cycles, release; imem_ready 2 cycles after each req:
//     req at addr 0x000, 0x002, 0x004; fetch_valid once per ack; pc_stall=0 only in ack cycles.
//  2. Outstanding fetch at 0x010; br_valid with br_target=0x123 in WAIT:
//     flush pulse; ack gives fetch_valid=0, pc_redirect=1, pc_target=0x122; next req addr 0x122.
//  3. Two branches (0x040 then 0x080) in one WAIT window: single redirect to 0x080, two flush pulses.
//  4. ifq_full=1 during ack: HOLD, no imem_req until ifq_full=0; then req 1 cycle later at pc_cur.
//  5. stop_req and br_valid same cycle in HOLD: HALT, halted=1, no redirect, no further imem_req;
//     rst low clears halted.
//  6. imem_ready never asserted, TIMEOUT=15: fetch_err=1 and halted=1 exactly 15 cycles after WAIT entry;
//     a late imem_ready produces no fetch_valid.

Source files
------------

// File: rtl/spu_fetch_pkg.sv
// Shared definitions for the SPU instruction-fetch front end.
//   - fetch_state_e   : fetch sequencer FSM states (3-bit encoding)
//   - INSTR_PAIR_STEP : PC increment per fetched instruction pair
//   - ADDR_W_DEF      : default PC / instruction-address width
package spu_fetch_pkg;

  localparam int ADDR_W_DEF      = 10;
  localparam int INSTR_PAIR_STEP = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting on instruction memory.
//   clk, rst : clock, synchronous active-low reset
//   clr      : zero the count (has priority over en)
//   en       : advance the count by one
//   expire   : count has reached TIMEOUT-1
module fetch_timeout_ctr #(
  parameter  int TIMEOUT = 15,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// SPU instruction-fetch sequencer: steps the PC one instruction pair per
// fetch, runs the req/ready handshake to instruction memory, applies branch
// and stop redirects, squashes stale fetches and halts on stop or timeout.
//   clk, rst            : clock, synchronous active-low reset
//   pc_cur              : current PC
//   pc_stall/redirect   : PC hold / load pc_target instead of +2
//   pc_target           : redirect target, LSB always 0
//   imem_req/addr/ready : instruction-memory handshake
//   fetch_valid         : pair forwarded to decode queue
//   ifq_full            : decode queue full, blocks next fetch
//   hazard_stall        : hazard unit blocks next fetch
//   br_valid/br_target  : taken branch resolved
//   stop_req            : stop instruction retired
//   flush               : 1-cycle decode-queue discard pulse
//   halted, fetch_err   : sticky status, cleared only by reset
// Addresses are documented MSB-first (bit 0 = MSB); here they are declared
// [ADDR_W-1:0], so the documented "last bit" is index 0 (the LSB).
module fetch_sequencer
  import spu_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic              pc_stall,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  output logic              fetch_valid,
  input  logic              ifq_full,
  input  logic              hazard_stall,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stop_req,
  output logic              flush,
  output logic              halted,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              pend_v_q, pend_v_d;
  logic              squash_q, squash_d;
  logic              stop_pend_q, stop_pend_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;

  logic              go, expire, ctr_clr;
  logic [ADDR_W-1:0] br_tgt;
  // WAIT-state view of the pending redirect including this cycle's events
  logic              w_sq, w_pv, w_sp;
  logic [ADDR_W-1:0] w_tg;
  logic              br_lsb_unused;

  assign go            = !ifq_full && !hazard_stall;
  assign br_tgt        = {br_target[ADDR_W-1:1], 1'b0};
  assign br_lsb_unused = br_target[0];
  assign ctr_clr       = (state_q != ST_WAIT) || imem_ready;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (ctr_clr),
    .en     (1'b1),
    .expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_tgt_d  = pend_tgt_q;
    pend_v_d    = pend_v_q;
    squash_d    = squash_q;
    stop_pend_d = stop_pend_q;
    halted_d    = halted_q;
    err_d       = err_q;
    pc_stall    = 1'b1;
    pc_redirect = 1'b0;
    pc_target   = '0;
    imem_req    = 1'b0;
    imem_addr   = addr_q;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    w_sq        = squash_q;
    w_pv        = pend_v_q;
    w_sp        = stop_pend_q;
    w_tg        = pend_tgt_q;

    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (stop_req) begin
          flush    = 1'b1;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (br_valid) begin
          pc_stall    = 1'b0;
          pc_redirect = 1'b1;
          pc_target   = br_tgt;
          flush       = 1'b1;
          state_d     = ST_FETCH;
        end else if (go) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        imem_req    = 1'b1;
        imem_addr   = pc_cur;
        addr_d      = pc_cur;
        pend_v_d    = 1'b0;
        squash_d    = 1'b0;
        stop_pend_d = 1'b0;
        state_d     = ST_WAIT;
        if (stop_req) begin
          flush    = 1'b1;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (br_valid) begin
          // Redirect now; the request just issued is stale. pend_v stays 0
          // so the ack does not redirect a second time.
          pc_stall    = 1'b0;
          pc_redirect = 1'b1;
          pc_target   = br_tgt;
          flush       = 1'b1;
          squash_d    = 1'b1;
          pend_tgt_d  = br_tgt;
        end
      end

      ST_WAIT: begin
        if (stop_req) begin
          w_sp  = 1'b1;
          w_sq  = 1'b1;
          flush = 1'b1;
        end else if (br_valid) begin
          // youngest branch wins
          w_sq  = 1'b1;
          w_pv  = 1'b1;
          w_tg  = br_tgt;
          flush = 1'b1;
        end
        if (imem_ready) begin
          pend_v_d    = 1'b0;
          squash_d    = 1'b0;
          stop_pend_d = 1'b0;
          if (w_sp) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            if (!w_sq) begin
              fetch_valid = 1'b1;
              pc_stall    = 1'b0;
            end else if (w_pv) begin
              pc_stall    = 1'b0;
              pc_redirect = 1'b1;
              pc_target   = w_tg;
            end
            state_d = go ? ST_FETCH : ST_HOLD;
          end
        end else if (expire) begin
          pend_v_d    = 1'b0;
          squash_d    = 1'b0;
          stop_pend_d = 1'b0;
          err_d       = 1'b1;
          halted_d    = 1'b1;
          state_d     = ST_HALT;
        end else begin
          pend_v_d    = w_pv;
          squash_d    = w_sq;
          pend_tgt_d  = w_tg;
          stop_pend_d = w_sp;
        end
      end

      ST_HALT: ;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      pend_tgt_q  <= '0;
      pend_v_q    <= 1'b0;
      squash_q    <= 1'b0;
      stop_pend_q <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_v_q    <= pend_v_d;
      squash_q    <= squash_d;
      stop_pend_q <= stop_pend_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end

  assign halted    = halted_q;
  assign fetch_err = err_q;

endmodule
